exc_ctrl: RTL

Exception controller for the single-cycle LEGv8 core with exceptions. It generates the `ExtIRQ` request consumed by the main decoder and consumes the decoder's `EStatus` and `ERet` outputs. On an exception it:
- squashes the faulting instruction,
- redirects fetch to the vector,
- captures `ELR`/`ESR`,
- tracks handler residency until `ERET`.

It also manages the external-interrupt pending latch and the acknowledge back to the device.

---
 rtl/exc_pkg.sv | 23 ++
 rtl/irq_pending.sv | 35 +++
 rtl/exc_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// Optional feature macro: EXC_DOUBLE_FAULT_EN adds the FAULT state (double-fault halt).
package exc_pkg;

`ifdef EXC_DOUBLE_FAULT_EN
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StHandler = 2'd1,
    StFault   = 2'd2
  } exc_state_t;
`else
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StHandler = 2'd1
  } exc_state_t;
`endif

  localparam logic [3:0]  ESR_NONE   = 4'b0000;
  localparam logic [3:0]  ESR_IRQ    = 4'b0001;
  localparam logic [3:0]  ESR_UNDEF  = 4'b0010;
  localparam logic [63:0] EXC_VECTOR = 64'hD8;

endpackage

// File: rtl/irq_pending.sv
// External-interrupt pending latch: rising-edge detect on IrqLine plus a set/clear latch.
// Ports:
//   clk, reset (async, active-low), IrqLine (level request), Clear (IRQ exception taken),
//   Pending (latched request).
module irq_pending (
  input  logic clk,
  input  logic reset,
  input  logic IrqLine,
  input  logic Clear,
  output logic Pending
);

  logic irq_q;
  logic pending_q, pending_d;
  logic rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= IrqLine;
      pending_q <= pending_d;
    end
  end

  // A new edge arriving in the same cycle as the clear must not be lost, so set wins.
  always_comb begin
    rise      = IrqLine & ~irq_q;
    pending_d = rise | (pending_q & ~Clear);
  end

  assign Pending = pending_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller for the single-cycle LEGv8 core.
// Squashes faulting instructions, redirects fetch to EVector, captures ELR/ESR, tracks handler
// residency until ERET, and latches/acknowledges the external interrupt.
// Ports:
//   clk, reset (async, active-low), IrqLine, EStatus (cause, 0 = none), ERet, PC
//   ExtIRQ (request to decoder), EProc (next PC = EVector), EVector, ERetTaken (next PC = ELR),
//   Flush (kill writes), ELR, ESR, ExcAck (one-cycle ack), InHandler, Halt (double fault)
// Optional feature macro: EXC_DOUBLE_FAULT_EN -- an exception inside the handler halts the core
// in FAULT until reset; without it the nested instruction is just dropped.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned    N           = 64,
  parameter logic [N-1:0]   VECTOR_ADDR = N'(EXC_VECTOR)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         IrqLine,
  input  logic [3:0]   EStatus,
  input  logic         ERet,
  input  logic [N-1:0] PC,
  output logic         ExtIRQ,
  output logic         EProc,
  output logic [N-1:0] EVector,
  output logic         ERetTaken,
  output logic         Flush,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic         ExcAck,
  output logic         InHandler,
  output logic         Halt
);

  exc_state_t   state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         exc_ack_q;
  logic         irq_clear;
  logic         pending;
  logic         exc_req;
  logic         eproc, eret_taken, flush, halt;

  irq_pending u_irq_pending (
    .clk     (clk),
    .reset   (reset),
    .IrqLine (IrqLine),
    .Clear   (irq_clear),
    .Pending (pending)
  );

  assign exc_req = (EStatus != ESR_NONE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      elr_q     <= '0;
      esr_q     <= ESR_NONE;
      exc_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elr_q     <= elr_d;
      esr_q     <= esr_d;
      exc_ack_q <= irq_clear;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    elr_d     = elr_q;
    esr_d     = esr_q;
    irq_clear = 1'b0;
    unique case (state_q)
      StRun: begin
        if (exc_req) begin
          state_d   = StHandler;
          elr_d     = PC;
          esr_d     = EStatus;
          irq_clear = (EStatus == ESR_IRQ);
        end else if (ERet) begin
          // ERET outside a handler is an undefined instruction.
          state_d = StHandler;
          elr_d   = PC;
          esr_d   = ESR_UNDEF;
        end
      end
      StHandler: begin
        if (exc_req) begin
`ifdef EXC_DOUBLE_FAULT_EN
          state_d = StFault;
`else
          state_d = StHandler;
`endif
        end else if (ERet) begin
          state_d = StRun;
        end
      end
`ifdef EXC_DOUBLE_FAULT_EN
      StFault: state_d = StFault;
`endif
      default: state_d = StRun;
    endcase
  end

  // Output logic
  always_comb begin
    eproc      = 1'b0;
    eret_taken = 1'b0;
    flush      = 1'b0;
    halt       = 1'b0;
    unique case (state_q)
      StRun: begin
        eproc = exc_req | ERet;
        flush = exc_req | ERet;
      end
      StHandler: begin
        flush      = exc_req;
        eret_taken = ~exc_req & ERet;
      end
`ifdef EXC_DOUBLE_FAULT_EN
      StFault: begin
        flush = 1'b1;
        halt  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign EProc     = reset & eproc;
  assign ERetTaken = reset & eret_taken;
  assign Flush     = reset & flush;
  assign Halt      = reset & halt;
  assign ExtIRQ    = pending & (state_q == StRun);
  assign InHandler = (state_q == StHandler);
  assign ExcAck    = exc_ack_q;
  assign ELR       = elr_q;
  assign ESR       = esr_q;
  assign EVector   = VECTOR_ADDR;

endmodule
